// File: rtl/mc_ctrl_unit.sv
// rtl/mc_ctrl_unit.sv - multi-cycle RV32I control FSM with fetch/data handshakes and traps
`timescale 1ns/1ps
module mc_ctrl_unit #(
    parameter int TIMEOUT = 255,
    parameter int ALU_W   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_imem_rdata,
    input  logic             i_imem_ack,
    input  logic             i_dmem_ack,
    input  logic             i_br_less,
    input  logic             i_br_equal,
    input  logic             i_trap_clr,
    output logic             o_imem_req,
    output logic             o_dmem_req,
    output logic             o_dmem_wren,
    output logic [31:0]      o_instr,
    output logic             o_pc_wren,
    output logic             o_pc_sel,
    output logic             o_br_un,
    output logic             o_rd_wren,
    output logic             o_opa_sel,
    output logic             o_opb_sel,
    output logic [ALU_W-1:0] o_alu_op,
    output logic [1:0]       o_wb_sel,
    output logic             o_insn_vld,
    output logic             o_trap,
    output logic [1:0]       o_trap_cause
);
    localparam int             CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit             TMO_EN = (TIMEOUT > 0);
    localparam logic [CW-1:0]  C_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0]  C_MAX  = '1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [2:0] {C_ALU, C_JUMP, C_LOAD, C_STORE, C_BRANCH} class_t;

    state_t        r_state, w_next;
    class_t        r_class, w_class;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_instr;
    logic [1:0]    r_cause, r_wb, w_wb;
    logic [3:0]    r_alu, w_alu;
    logic          r_opa, r_opb, r_br_un, w_opa, w_opb, w_br_un, w_legal, w_taken, w_timeout;
    logic [6:0]    w_op, w_f7;
    logic [2:0]    w_f3;

    assign w_op      = r_instr[6:0];
    assign w_f3      = r_instr[14:12];
    assign w_f7      = r_instr[31:25];
    assign w_timeout = TMO_EN && (r_cnt == C_LAST);

    function automatic logic [3:0] f_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    f_alu = alt ? 4'd1 : 4'd0;
            3'd1:    f_alu = 4'd2;
            3'd2:    f_alu = 4'd3;
            3'd3:    f_alu = 4'd4;
            3'd4:    f_alu = 4'd5;
            3'd5:    f_alu = alt ? 4'd7 : 4'd6;
            3'd6:    f_alu = 4'd8;
            default: f_alu = 4'd9;
        endcase
    endfunction

    always_comb begin
        w_legal = 1'b1;
        w_class = C_ALU;
        w_alu   = 4'd0;
        w_opa   = 1'b0;
        w_opb   = 1'b1;
        w_wb    = 2'b00;
        w_br_un = 1'b0;
        case (w_op)
            7'b0110011: begin
                w_opb   = 1'b0;
                w_alu   = f_alu(w_f3, w_f7[5]);
                w_legal = (w_f7 == 7'b0) || (w_f7 == 7'b0100000 && (w_f3 == 3'd0 || w_f3 == 3'd5));
            end
            7'b0010011: begin
                // Only the shift-right immediates carry an ALU selector in funct7
                w_alu = f_alu(w_f3, (w_f3 == 3'd5) && w_f7[5]);
                if (w_f3 == 3'd1) w_legal = (w_f7 == 7'b0);
                if (w_f3 == 3'd5) w_legal = (w_f7 == 7'b0) || (w_f7 == 7'b0100000);
            end
            7'b0110111: w_alu = 4'd10;
            7'b0010111: w_opa = 1'b1;
            7'b1101111: begin w_class = C_JUMP; w_opa = 1'b1; w_wb = 2'b10; end
            7'b1100111: begin w_class = C_JUMP; w_wb = 2'b10; w_legal = (w_f3 == 3'd0); end
            7'b0000011: begin
                w_class = C_LOAD;
                w_wb    = 2'b01;
                w_legal = !(w_f3 == 3'd3 || w_f3 == 3'd6 || w_f3 == 3'd7);
            end
            7'b0100011: begin w_class = C_STORE; w_legal = (w_f3 <= 3'd2); end
            7'b1100011: begin
                w_class = C_BRANCH;
                w_opa   = 1'b1;
                w_br_un = w_f3[1];
                w_legal = !(w_f3 == 3'd2 || w_f3 == 3'd3);
            end
            default: w_legal = 1'b0;
        endcase
        if (r_instr[1:0] != 2'b11) w_legal = 1'b0;
    end

    always_comb begin
        case (w_f3)
            3'd0:       w_taken = i_br_equal;
            3'd1:       w_taken = !i_br_equal;
            3'd4, 3'd6: w_taken = i_br_less;
            3'd5, 3'd7: w_taken = !i_br_less;
            default:    w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_instr <= 32'd0;
            r_cause <= 2'b00;
            r_cnt   <= '0;
            r_class <= C_ALU;
            r_alu   <= 4'd0;
            r_opa   <= 1'b0;
            r_opb   <= 1'b0;
            r_wb    <= 2'b00;
            r_br_un <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FETCH, S_MEM: begin
                    if ((r_state == S_FETCH) ? i_imem_ack : i_dmem_ack) begin
                        if (r_state == S_FETCH) r_instr <= i_imem_rdata;
                        r_cnt <= '0;
                    end else if (w_timeout) begin
                        r_cnt   <= '0;
                        r_cause <= (r_state == S_FETCH) ? 2'b01 : 2'b10;
                    end else if (r_cnt != C_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    r_class <= w_class;
                    r_alu   <= w_alu;
                    r_opa   <= w_opa;
                    r_opb   <= w_opb;
                    r_wb    <= w_wb;
                    r_br_un <= w_br_un;
                    if (!w_legal) r_cause <= 2'b00;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next       = r_state;
        o_imem_req   = 1'b0;
        o_dmem_req   = 1'b0;
        o_dmem_wren  = 1'b0;
        o_pc_wren    = 1'b0;
        o_pc_sel     = 1'b0;
        o_rd_wren    = 1'b0;
        o_insn_vld   = 1'b0;
        o_trap       = 1'b0;
        o_br_un      = 1'b0;
        o_opa_sel    = 1'b0;
        o_opb_sel    = 1'b0;
        o_alu_op     = '0;
        o_wb_sel     = 2'b00;
        o_instr      = r_instr;
        o_trap_cause = r_cause;
        if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
            o_br_un   = r_br_un;
            o_opa_sel = r_opa;
            o_opb_sel = r_opb;
            o_alu_op  = ALU_W'(r_alu);
            o_wb_sel  = r_wb;
        end
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                o_imem_req = 1'b1;
                if (i_imem_ack)     w_next = S_DECODE;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (r_class == C_BRANCH) begin
                    o_pc_wren  = 1'b1;
                    o_pc_sel   = w_taken;
                    o_insn_vld = 1'b1;
                    w_next     = S_FETCH;
                end else if (r_class == C_LOAD || r_class == C_STORE) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                o_dmem_req  = 1'b1;
                o_dmem_wren = (r_class == C_STORE);
                if (i_dmem_ack) begin
                    if (r_class == C_STORE) begin
                        o_pc_wren  = 1'b1;
                        o_insn_vld = 1'b1;
                        w_next     = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_WB: begin
                o_rd_wren  = 1'b1;
                o_pc_wren  = 1'b1;
                o_insn_vld = 1'b1;
                o_pc_sel   = (r_class == C_JUMP);
                w_next     = S_FETCH;
            end
            S_TRAP: begin
                o_trap = 1'b1;
                if (i_trap_clr) w_next = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mc_ctrl_unit.sv
// tb/tb_mc_ctrl_unit.sv - self-checking bench for mc_ctrl_unit against a per-instruction trace model
`timescale 1ns/1ps
module tb_mc_ctrl_unit;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_imem_rdata = 32'd0;
    logic        i_imem_ack = 1'b0, i_dmem_ack = 1'b0, i_br_less = 1'b0, i_br_equal = 1'b0, i_trap_clr = 1'b0;
    logic        o_imem_req, o_dmem_req, o_dmem_wren, o_pc_wren, o_pc_sel, o_br_un, o_rd_wren;
    logic        o_opa_sel, o_opb_sel, o_insn_vld, o_trap;
    logic [31:0] o_instr;
    logic [3:0]  o_alu_op;
    logic [1:0]  o_wb_sel, o_trap_cause;

    mc_ctrl_unit #(.TIMEOUT(TMO), .ALU_W(4)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_imem_rdata(i_imem_rdata), .i_imem_ack(i_imem_ack),
        .i_dmem_ack(i_dmem_ack), .i_br_less(i_br_less), .i_br_equal(i_br_equal), .i_trap_clr(i_trap_clr),
        .o_imem_req(o_imem_req), .o_dmem_req(o_dmem_req), .o_dmem_wren(o_dmem_wren), .o_instr(o_instr),
        .o_pc_wren(o_pc_wren), .o_pc_sel(o_pc_sel), .o_br_un(o_br_un), .o_rd_wren(o_rd_wren),
        .o_opa_sel(o_opa_sel), .o_opb_sel(o_opb_sel), .o_alu_op(o_alu_op), .o_wb_sel(o_wb_sel),
        .o_insn_vld(o_insn_vld), .o_trap(o_trap), .o_trap_cause(o_trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic imem_req, dmem_req, dmem_wren, pc_wren, pc_sel, br_un, rd_wren, opa, opb;
        logic [3:0]  alu;
        logic [1:0]  wb;
        logic        insn_vld, trap;
        logic [1:0]  cause;
        logic [31:0] instr;
    } exp_t;
    typedef struct packed { logic iack, dack, clr; } in_t;

    exp_t        tr[$];
    in_t         iv[$];
    exp_t        cq[$];
    int          tests = 0, fails = 0;
    logic [31:0] m_instr = 32'd0;
    logic [1:0]  m_cause = 2'b00;

    function automatic exp_t dut_outs();
        exp_t g;
        g = '{o_imem_req, o_dmem_req, o_dmem_wren, o_pc_wren, o_pc_sel, o_br_un, o_rd_wren,
              o_opa_sel, o_opb_sel, o_alu_op, o_wb_sel, o_insn_vld, o_trap, o_trap_cause, o_instr};
        return g;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (cq.size() > 0) begin
            exp_t e, g;
            e = cq.pop_front();
            g = dut_outs();
            tests++;
            if (g !== e) begin
                fails++;
                $display("FAIL trace t=%0t got=%h want=%h", $time, g, e);
            end
        end
    end

    // Architectural decode straight from the ISA rules: ALU op comes from funct3, +1 for SUB/SRA.
    task automatic mdec(input logic [31:0] x, output logic legal, output int cls, output logic [3:0] alu,
                        output logic opa, output logic opb, output logic [1:0] wb, output logic brun);
        logic [3:0] tab [8];
        logic [2:0] f3;
        logic [6:0] f7;
        logic       alt;
        tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        f3 = x[14:12]; f7 = x[31:25]; alt = (f7 == 7'h20);
        legal = 1'b1; cls = 0; alu = 4'd0; opa = 1'b0; opb = 1'b1; wb = 2'd0; brun = 1'b0;
        case (x[6:0])
            7'h33: begin opb = 1'b0; alu = tab[f3] + {3'd0, alt}; legal = (f7 == 0) || (alt && (f3 == 0 || f3 == 5)); end
            7'h13: begin
                alu = tab[f3] + {3'd0, (f3 == 5) && alt};
                if (f3 == 1) legal = (f7 == 0);
                if (f3 == 5) legal = (f7 == 0) || alt;
            end
            7'h37: alu = 4'd10;
            7'h17: opa = 1'b1;
            7'h6f: begin cls = 1; opa = 1'b1; wb = 2'd2; end
            7'h67: begin cls = 1; wb = 2'd2; legal = (f3 == 0); end
            7'h03: begin cls = 2; wb = 2'd1; legal = !(f3 == 3 || f3 >= 6); end
            7'h23: begin cls = 3; legal = (f3 <= 2); end
            7'h63: begin cls = 4; opa = 1'b1; brun = x[13]; legal = !(f3 == 2 || f3 == 3); end
            default: legal = 1'b0;
        endcase
        if (x[1:0] != 2'b11) legal = 1'b0;
    endtask

    task automatic push(input exp_t e, input in_t v);
        tr.push_back(e);
        iv.push_back(v);
    endtask

    task automatic push_trap(input logic [31:0] ins, input logic [1:0] cause);
        exp_t e;
        e = '0; e.trap = 1'b1; e.cause = cause; e.instr = ins;
        push(e, '{1'b1, 1'b1, 1'b0});
        push(e, '{1'b0, 1'b0, 1'b1});
    endtask

    task automatic build(input logic [31:0] ins, input int idl, input int ddl, input logic lt, input logic eq,
                         input logic [31:0] cur_i, input logic [1:0] cur_c,
                         output logic [31:0] ni, output logic [1:0] nc);
        exp_t e, base;
        in_t  v;
        logic legal, opa, opb, brun, taken;
        logic [3:0] alu;
        logic [1:0] wb;
        int cls;
        tr.delete(); iv.delete();
        ni = cur_i; nc = cur_c;
        for (int k = 0; k < TMO; k++) begin
            e = '0; e.imem_req = 1'b1; e.instr = ni; e.cause = nc;
            v = '0; v.iack = (k == idl);
            push(e, v);
            if (k == idl) break;
        end
        if (idl >= TMO) begin nc = 2'd1; push_trap(ni, nc); return; end
        ni = ins;
        mdec(ins, legal, cls, alu, opa, opb, wb, brun);
        e = '0; e.instr = ni; e.cause = nc;
        push(e, '0);
        if (!legal) begin nc = 2'd0; push_trap(ni, nc); return; end
        base = '0; base.instr = ni; base.cause = nc; base.alu = alu; base.opa = opa; base.opb = opb;
        base.wb = wb; base.br_un = brun;
        e = base;
        if (cls == 4) begin
            taken = (ins[14] ? lt : eq) ^ ins[12];
            e.pc_wren = 1'b1; e.pc_sel = taken; e.insn_vld = 1'b1;
            push(e, '0);
            return;
        end
        push(e, '0);
        if (cls == 2 || cls == 3) begin
            for (int k = 0; k < TMO; k++) begin
                e = base; e.dmem_req = 1'b1; e.dmem_wren = (cls == 3);
                v = '0; v.dack = (k == ddl);
                if (k == ddl && cls == 3) begin e.pc_wren = 1'b1; e.insn_vld = 1'b1; end
                push(e, v);
                if (k == ddl) break;
            end
            if (ddl >= TMO) begin nc = 2'd2; push_trap(ni, nc); return; end
            if (cls == 3) return;
        end
        e = base; e.rd_wren = 1'b1; e.pc_wren = 1'b1; e.insn_vld = 1'b1; e.pc_sel = (cls == 1);
        push(e, '0);
    endtask

    task automatic run(input logic [31:0] ins, input int idl, input int ddl, input logic lt, input logic eq);
        logic [31:0] ni;
        logic [1:0]  nc;
        build(ins, idl, ddl, lt, eq, m_instr, m_cause, ni, nc);
        for (int k = 0; k < tr.size(); k++) begin
            @(posedge clk); #1;
            i_imem_rdata = ins; i_imem_ack = iv[k].iack; i_dmem_ack = iv[k].dack;
            i_trap_clr = iv[k].clr; i_br_less = lt; i_br_equal = eq;
            cq.push_back(tr[k]);
        end
        m_instr = ni; m_cause = nc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        logic [31:0] ni;
        logic [1:0]  nc;
        logic        lg, a, b, bu;
        logic [3:0]  al;
        logic [1:0]  w;
        int          c;

        // Pin the model with hand-derived cycle counts and codes.
        build(32'h002081B3, 0, 0, 0, 0, 0, 0, ni, nc); chk("len_add", tr.size(), 4);
        chk("add_wb_rd", {tr[3].rd_wren, tr[3].insn_vld, tr[3].alu}, {1'b1, 1'b1, 4'd0});
        build(32'h00209463, 0, 0, 0, 0, 0, 0, ni, nc); chk("len_bne", tr.size(), 3);
        build(32'h0000A283, 0, 3, 0, 0, 0, 0, ni, nc); chk("len_lw_d3", tr.size(), 8);
        chk("lw_wb_sel", tr[7].wb, 2'b01);
        build(32'h0000A283, 0, 0, 0, 0, 0, 0, ni, nc); chk("len_lw", tr.size(), 5);
        build(32'h0020A223, 0, 0, 0, 0, 0, 0, ni, nc); chk("len_sw", tr.size(), 4);
        build(32'h0000007F, 10, 0, 0, 0, 0, 0, ni, nc); chk("tmo_cause", {tr[4].trap, tr[4].cause}, {1'b1, 2'b01});
        mdec(32'h40208133, lg, c, al, a, b, w, bu); chk("sub_alu", al, 4'd1);
        mdec(32'h4030D093, lg, c, al, a, b, w, bu); chk("srai_alu", al, 4'd7);

        repeat (2) @(posedge clk);
        #1 chk("rst_outs", dut_outs(), '0);
        i_rst_n = 1'b1;
        @(negedge clk) chk("idle_outs", dut_outs(), '0);

        run(32'h002081B3, 0, 0, 0, 0);
        run(32'h00209463, 0, 0, 0, 0);
        run(32'h00209463, 0, 0, 0, 1);
        run(32'h0000A283, 0, 3, 0, 0);
        run(32'h0020A223, 0, 0, 0, 0);
        run(32'h40208133, 2, 0, 0, 0);
        run(32'h4030D093, 0, 0, 0, 0);
        run(32'h008000EF, 0, 0, 0, 0);
        run(32'h00008067, 1, 0, 0, 0);
        run(32'h123452B7, 0, 0, 0, 0);
        run(32'h00001097, 0, 0, 0, 0);
        run(32'h0020E463, 0, 0, 1, 0);
        run(32'h0020D463, 0, 0, 0, 0);
        run(32'h0020D463, 0, 0, 1, 0);
        run(32'h0000007F, 0, 0, 0, 0);
        run(32'h0000B283, 0, 0, 0, 0);
        run(32'h40109093, 0, 0, 0, 0);
        run(32'h0020B223, 0, 0, 0, 0);
        run(32'h002081B3, 10, 0, 0, 0);
        run(32'h0000A283, 0, 10, 0, 0);
        run(32'h0020A223, 0, 2, 0, 0);

        @(posedge clk); #1; i_imem_rdata = 32'h0000A283; i_imem_ack = 1'b1; i_dmem_ack = 1'b0; i_trap_clr = 1'b0;
        @(posedge clk); #1; i_imem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_mem_req", {o_dmem_req, o_dmem_wren}, 2'b10);
        i_rst_n = 1'b0;
        #1 chk("rst_mid_mem", dut_outs(), '0);
        @(posedge clk); #1;
        i_rst_n = 1'b1;
        #1 chk("idle_after_rst", dut_outs(), '0);
        @(posedge clk); #1;
        chk("fetch_after_rst", {o_imem_req, o_dmem_req, o_instr}, {1'b1, 1'b0, 32'd0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
